nes_palette_loader: RTL and testbench
=====================================

// Module: nes_palette_loader
// PURPOSE
//  Runtime-loadable custom NES palette feeding the video stage's colour lookup.
//  Accepts a 192-byte palette file (64 entries x R,G,B 8-bit) from the HPS download channel.
//  Packs each entry to 15-bit BGR555 and stores it in a 64x15 dual-port RAM.
//  Serves 1-cycle registered lookups by 6-bit NES colour index. pal_valid tells the video stage
//  when to use this table instead of its built-in palettes.
// PARAMETERS
//  PAL_INDEX   8'd2   ioctl_index value identifying a palette download
//  PAL_BYTES   192    bytes in a complete palette file (64*3)
// PORTS
//  clk            in   1   system clock; all logic on posedge
//  reset          in   1   synchronous, active-high
//  ioctl_download in   1   high for the whole duration of any HPS download
//  ioctl_index    in   8   download target selector
//  ioctl_wr       in   1   one-cycle strobe, ioctl_dout valid
//  ioctl_addr     in   25  byte address of ioctl_dout within the file
//  ioctl_dout     in   8   download data byte
//  lookup_en      in   1   lookup strobe (video pixel enable)
//  color          in   6   NES colour index to look up
//  pixel          out  15  {B[7:3],G[7:3],R[7:3]} of the entry; same packing as built-in LUTs
//  pal_valid      out  1   complete custom palette held; video uses pixel when 1
//  load_error     out  1   last palette download was malformed (sticky until next download)
// BEHAVIOUR
//  Reset: state=IDLE, pixel=0, pal_valid=0, load_error=0, byte/entry counters=0.
//   RAM contents are not cleared.
//  FSM IDLE -> LOAD when ioctl_download=1 && ioctl_index==PAL_INDEX (rising of the match).
//   On entry: pal_valid<=0, load_error<=0, byte_cnt<=0, phase<=0.
//  LOAD, per ioctl_wr:
//   - Require ioctl_addr==byte_cnt (strictly sequential from 0).
//     Mismatch: load_error<=1, go to ERR; no further RAM writes this download.
//   - byte_cnt<PAL_BYTES: phase 0 latches R[7:3], phase 1 latches G[7:3].
//     Phase 2 writes {dout[7:3],G,R} to RAM[byte_cnt/3] in the same clock edge.
//     Phase cycles 0,1,2,0... via a counter; no divider.
//   - byte_cnt>=PAL_BYTES: byte ignored, no error (padding permitted). byte_cnt saturates.
//  LOAD -> IDLE on ioctl_download falling:
//   - byte_cnt>=PAL_BYTES: pal_valid<=1.
//   - Otherwise: load_error<=1, pal_valid stays 0.
//  ERR -> IDLE on ioctl_download falling; pal_valid stays 0.
//  A download with another ioctl_index is ignored in every state. It does not touch
//   pal_valid or load_error.
//  Lookup: lookup_en=1 at edge N -> pixel = RAM[color] after edge N (1-cycle latency).
//   lookup_en=0 holds pixel.
//  Read/write to the same entry in one cycle: read returns the old data (read-before-write).
//  pal_valid is 0 throughout LOAD/ERR, so the video stage never shows a partially loaded table.
//  Reset mid-download: FSM returns to IDLE, pal_valid=0. Remaining bytes of that download are
//   ignored until ioctl_download falls and a new matching download starts.
//  ioctl_wr with ioctl_download=0 is ignored.
// TESTING
//  1 Full load of 192 sequential bytes, entry k = (8k,4k,2k); then lookup color=5.
//    -> pixel={5'd1,5'd2,5'd5}, i.e. {B=10>>3, G=20>>3, R=40>>3}. pal_valid=1 one cycle
//    after download falls. load_error=0.
//  2 Download of 100 bytes then ioctl_download falls -> pal_valid=0, load_error=1.
//    Entries 0..32 hold new data.
//  3 Address skip (addr 10 sent after 8) -> load_error=1 immediately, no write to entry 3.
//    pal_valid=0 after end of download.
//  4 200-byte file (8 pad bytes) -> pal_valid=1, load_error=0.
//    Entry 63 = bytes 189..191, unaffected by padding.
//  5 Download with ioctl_index=0 during valid palette -> pal_valid stays 1, RAM unchanged.
//    Lookup of entry 0 and entry 63 returns prior values.
//  6 reset asserted at byte 90 of a load -> pal_valid=0, state IDLE.
//    Rest of the download is ignored. A subsequent full load sets pal_valid=1.

Source files
------------

// File: rtl/nes_palette_loader.sv
// Runtime-loadable NES palette: packs a 192-byte RGB download into a
// 64x15 BGR555 RAM and serves registered colour lookups to the video stage.
module nes_palette_loader #(
    parameter logic [7:0] PAL_INDEX = 8'd2,
    parameter int         PAL_BYTES = 192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        lookup_en,
    input  logic [5:0]  color,
    output logic [14:0] pixel,
    output logic        pal_valid,
    output logic        load_error
);

    localparam logic [7:0] FILE_LEN = PAL_BYTES[7:0];

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ERR
    } state_t;

    state_t state, state_nx;

    logic [14:0] mem [64];
    logic        match;
    logic        match_q;
    logic        start;
    logic        wr_ok;
    logic        in_file;
    logic        addr_ok;
    logic        clr;
    logic        adv;
    logic        ram_we;
    logic        set_err;
    logic        set_valid;
    logic [7:0]  byte_cnt;
    logic [1:0]  phase;
    logic [5:0]  entry_cnt;
    logic [4:0]  r_q;
    logic [4:0]  g_q;
    logic        unused_low;

    assign unused_low = ^ioctl_dout[2:0];

    assign match   = ioctl_download && (ioctl_index == PAL_INDEX);
    assign start   = match && !match_q;
    assign wr_ok   = ioctl_wr && match;
    assign in_file = byte_cnt < FILE_LEN;
    assign addr_ok = ioctl_addr == {17'd0, byte_cnt};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        clr       = 1'b0;
        adv       = 1'b0;
        ram_we    = 1'b0;
        set_err   = 1'b0;
        set_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LOAD;
                    clr      = 1'b1;
                end
            end
            LOAD: begin
                if (!ioctl_download) begin
                    state_nx = IDLE;
                    if (in_file) set_err   = 1'b1;
                    else         set_valid = 1'b1;
                end else if (wr_ok && in_file) begin
                    if (!addr_ok) begin
                        state_nx = ERR;
                        set_err  = 1'b1;
                    end else begin
                        adv    = 1'b1;
                        ram_we = (phase == 2'd2);
                    end
                end
            end
            ERR: begin
                if (!ioctl_download) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Edge detector is primed from the live match on reset so a download
    // already in flight is not mistaken for a fresh one.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_q    <= match;
            byte_cnt   <= '0;
            phase      <= '0;
            entry_cnt  <= '0;
            r_q        <= '0;
            g_q        <= '0;
            pal_valid  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            match_q <= match;
            if (clr) begin
                byte_cnt   <= '0;
                phase      <= '0;
                entry_cnt  <= '0;
                pal_valid  <= 1'b0;
                load_error <= 1'b0;
            end
            if (set_err)   load_error <= 1'b1;
            if (set_valid) pal_valid  <= 1'b1;
            if (adv) begin
                byte_cnt <= byte_cnt + 8'd1;
                unique case (phase)
                    2'd0: begin
                        r_q   <= ioctl_dout[7:3];
                        phase <= 2'd1;
                    end
                    2'd1: begin
                        g_q   <= ioctl_dout[7:3];
                        phase <= 2'd2;
                    end
                    default: begin
                        phase     <= 2'd0;
                        entry_cnt <= entry_cnt + 6'd1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[entry_cnt] <= {ioctl_dout[7:3], g_q, r_q};
    end

    always_ff @(posedge clk) begin
        if (reset)          pixel <= '0;
        else if (lookup_en) pixel <= mem[color];
    end

endmodule

// File: tb/tb_nes_palette_loader.sv
// Randomized bench for nes_palette_loader: a byte-level palette model
// predicts lookups into a scoreboard queue drained by a monitor.
module tb_nes_palette_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        lookup_en;
    logic [5:0]  color;
    logic [14:0] pixel;
    logic        pal_valid;
    logic        load_error;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  fbytes [256];
    logic [14:0] model_ram [64];
    logic        exp_valid = 1'b0;
    logic        exp_err = 1'b0;
    logic [14:0] exp_q [$];

    always #5 clk = ~clk;

    nes_palette_loader dut (
        .clk(clk),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .lookup_en(lookup_en),
        .color(color),
        .pixel(pixel),
        .pal_valid(pal_valid),
        .load_error(load_error)
    );

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [14:0] pack(input logic [7:0] r,
                                         input logic [7:0] g,
                                         input logic [7:0] b);
        return {b[7:3], g[7:3], r[7:3]};
    endfunction

    // Monitor: every accepted lookup is answered one edge later.
    always @(posedge clk) begin
        if (!reset && lookup_en) begin
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL lookup_extra: got %0h want none", pixel);
            end else begin
                check("lookup", pixel, exp_q.pop_front());
            end
        end
    end

    task automatic randomize_file();
        for (int i = 0; i < 256; i++) fbytes[i] = 8'($urandom);
    endtask

    task automatic download(input logic [7:0] idx, input int n,
                            input int bad_pos, input int rst_pos,
                            input int peek_pos);
        bit err = 0;
        bit aborted = 0;
        bit hit = (idx == 8'd2);
        @(negedge clk);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int p = 0; p < n; p++) begin
            if (p == rst_pos) begin
                reset = 1'b1;
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1;
                check("rst_mid_valid", pal_valid, 0);
            end
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(p == bad_pos ? p + 1 : p);
            ioctl_dout = fbytes[p];
            if (p == peek_pos) begin
                lookup_en = 1'b1;
                color     = 6'(p / 3);
                exp_q.push_back(model_ram[p/3]);
            end
            if (hit && !aborted && !err && p < 192) begin
                if (p == bad_pos)
                    err = 1;
                else if (p % 3 == 2)
                    model_ram[p/3] = pack(fbytes[p-2], fbytes[p-1], fbytes[p]);
            end
            @(negedge clk);
            ioctl_wr  = 1'b0;
            lookup_en = 1'b0;
            if (p == bad_pos && hit) check("err_immediate", load_error, 1);
            if (p == 50 && hit && !aborted)
                check("valid_low_in_load", pal_valid, 0);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        ioctl_download = 1'b0;
        @(negedge clk);
        if (hit) begin
            if (aborted) begin
                exp_valid = 1'b0;
                exp_err   = 1'b0;
            end else if (err || n < 192) begin
                exp_valid = 1'b0;
                exp_err   = 1'b1;
            end else begin
                exp_valid = 1'b1;
                exp_err   = 1'b0;
            end
        end
        check("pal_valid", pal_valid, exp_valid);
        check("load_error", load_error, exp_err);
    endtask

    task automatic lookup_exp(input logic [5:0] c, input logic [14:0] e);
        @(negedge clk);
        lookup_en = 1'b1;
        color     = c;
        exp_q.push_back(e);
        @(negedge clk);
        lookup_en = 1'b0;
        color     = 6'($urandom);
        @(negedge clk);
        check("hold", pixel, e);
    endtask

    task automatic lookup(input logic [5:0] c);
        lookup_exp(c, model_ram[c]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        lookup_en      = 1'b0;
        color          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_pixel", pixel, 0);
        check("rst_valid", pal_valid, 0);
        check("rst_error", load_error, 0);

        // Full sequential load, entry k = (8k,4k,2k)
        for (int k = 0; k < 64; k++) begin
            fbytes[3*k]   = 8'(8 * k);
            fbytes[3*k+1] = 8'(4 * k);
            fbytes[3*k+2] = 8'(2 * k);
        end
        download(8'd2, 192, -1, -1, -1);
        lookup_exp(6'd5, 15'b00001_00010_00101);
        lookup(6'd0);
        lookup(6'd63);
        repeat (3) lookup(6'($urandom));

        // Truncated download
        randomize_file();
        download(8'd2, 100, -1, -1, -1);
        lookup(6'd0);
        lookup(6'd32);
        lookup(6'd33);

        // Address skip after byte 8
        randomize_file();
        download(8'd2, 30, 9, -1, -1);
        lookup(6'd2);
        lookup(6'd3);

        // Padded file, with a same-cycle read of the entry being written
        randomize_file();
        download(8'd2, 200, -1, -1, 122);
        lookup(6'd63);
        lookup(6'd40);
        lookup(6'd0);

        // Foreign-index download must not disturb the table
        randomize_file();
        download(8'd0, 192, -1, -1, -1);
        lookup(6'd0);
        lookup(6'd63);

        // Stray write strobe without a download
        @(negedge clk);
        ioctl_index = 8'd2;
        ioctl_wr    = 1'b1;
        ioctl_addr  = '0;
        ioctl_dout  = 8'hff;
        @(negedge clk);
        ioctl_wr = 1'b0;
        lookup(6'd0);

        // Reset in the middle of a load, then a clean reload
        randomize_file();
        download(8'd2, 192, -1, 90, -1);
        lookup(6'd10);
        randomize_file();
        download(8'd2, 192, -1, -1, -1);
        repeat (20) lookup(6'($urandom));

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
